// File: rtl/sdram_init_seq.sv
// SDRAM power-up / initialisation sequencer.
// Runs the power-up wait, PRECHARGE ALL, a set number of AUTO REFRESH commands and a
// MODE REGISTER SET, then releases the bus by raising sdram_init_done. A re-init request
// accepted while done replays the command part of the sequence without the power-up wait.
module sdram_init_seq #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int POWERUP_US   = 200,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int REFRESH_NUM  = 2,
  parameter int CAS_LATENCY  = 3,
  parameter int BURST_LEN    = 4,
  parameter int BURST_TYPE   = 0,
  parameter int WRITE_BURST  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_req,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmds,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addrs,
  output logic        sdram_init_done
);

  localparam int N_PU  = CLK_FREQ_MHZ * POWERUP_US;
  localparam int MAX_A = (N_PU > T_RP) ? N_PU : T_RP;
  localparam int MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam int RW    = $clog2(REFRESH_NUM + 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [2:0] ST_WAIT_PU = 3'd0;
  localparam logic [2:0] ST_PRE     = 3'd1;
  localparam logic [2:0] ST_TRP     = 3'd2;
  localparam logic [2:0] ST_REF     = 3'd3;
  localparam logic [2:0] ST_TRFC    = 3'd4;
  localparam logic [2:0] ST_MRS     = 3'd5;
  localparam logic [2:0] ST_TMRD    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  localparam logic [2:0] BL_CODE = (BURST_LEN == 1) ? 3'b000 :
                                   (BURST_LEN == 2) ? 3'b001 :
                                   (BURST_LEN == 4) ? 3'b010 :
                                   (BURST_LEN == 8) ? 3'b011 : 3'b111;

  localparam logic [12:0] MODE_WORD = {3'b000, 1'(WRITE_BURST), 2'b00, 3'(CAS_LATENCY),
                                       1'(BURST_TYPE), BL_CODE};

  if (!(CAS_LATENCY == 2 || CAS_LATENCY == 3)) begin : g_bad_cl
    $error("sdram_init_seq: illegal CAS_LATENCY %0d", CAS_LATENCY);
  end
  if (!(BURST_LEN == 0 || BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 ||
        BURST_LEN == 8)) begin : g_bad_bl
    $error("sdram_init_seq: illegal BURST_LEN %0d", BURST_LEN);
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] ref_q, ref_d;
  logic          refs_done;
  logic [3:0]    cmd_d;
  logic [12:0]   addr_d;

  // Next state: wait states count from 1 up to T_x-1; a T_x of 1 skips the wait state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_d     = ref_q;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    refs_done = (ref_q == RW'(REFRESH_NUM));
    case (state_q)
      ST_WAIT_PU: begin
        if (cnt_q == CW'(N_PU)) begin
          state_d = ST_PRE;
          ref_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRE: begin
        if (T_RP == 1) begin
          state_d = ST_REF;
        end else begin
          state_d = ST_TRP;
          cnt_d   = CW'(1);
        end
      end
      ST_TRP: begin
        if (cnt_q == CW'(T_RP - 1)) state_d = ST_REF;
        else                        cnt_d   = cnt_inc;
      end
      ST_REF: begin
        if (T_RFC == 1) begin
          state_d = refs_done ? ST_MRS : ST_REF;
        end else begin
          state_d = ST_TRFC;
          cnt_d   = CW'(1);
        end
      end
      ST_TRFC: begin
        if (cnt_q == CW'(T_RFC - 1)) state_d = refs_done ? ST_MRS : ST_REF;
        else                         cnt_d   = cnt_inc;
      end
      ST_MRS: begin
        if (T_MRD == 1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TMRD;
          cnt_d   = CW'(1);
        end
      end
      ST_TMRD: begin
        if (cnt_q == CW'(T_MRD - 1)) state_d = ST_DONE;
        else                         cnt_d   = cnt_inc;
      end
      default: begin
        if (init_req) begin
          state_d = ST_PRE;
          ref_d   = '0;
        end
      end
    endcase
    // Count each refresh as it is issued; saturates at REFRESH_NUM.
    if (state_d == ST_REF && !refs_done) ref_d = ref_q + RW'(1);
  end

  // Command and address for the state being entered, so outputs change with the state.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = 13'h1FFF;
    case (state_d)
      ST_PRE:  cmd_d = CMD_PRE;
      ST_REF:  cmd_d = CMD_REF;
      ST_MRS: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_WORD;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_WAIT_PU;
      cnt_q           <= '0;
      ref_q           <= '0;
      sdram_cke       <= 1'b0;
      sdram_cmds      <= CMD_NOP;
      sdram_ba        <= 2'b00;
      sdram_addrs     <= 13'h1FFF;
      sdram_init_done <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ref_q           <= ref_d;
      sdram_cke       <= 1'b1;
      sdram_cmds      <= cmd_d;
      sdram_ba        <= 2'b00;
      sdram_addrs     <= addr_d;
      sdram_init_done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three instances (default timing, back-to-back timing,
// alternate mode word) compared every cycle against a schedule computed from the
// command-offset rules, plus a checkpoint table and hand-written re-init/reset sequences.
module tb_sdram_init_seq;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  typedef struct {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
  } exp_t;

  typedef struct {
    int          cycle;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_req = 1'b0;
  logic no_req = 1'b0;

  logic a_cke, b_cke, c_cke, a_done, b_done, c_done;
  logic [3:0]  a_cmds, b_cmds, c_cmds;
  logic [1:0]  a_ba, b_ba, c_ba;
  logic [12:0] a_addrs, b_addrs, c_addrs;

  always #5 clk = ~clk;

  sdram_init_seq dut_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .sdram_cke(a_cke), .sdram_cmds(a_cmds),
    .sdram_ba(a_ba), .sdram_addrs(a_addrs), .sdram_init_done(a_done)
  );

  sdram_init_seq #(
    .CLK_FREQ_MHZ(10), .POWERUP_US(1), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_NUM(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(no_req), .sdram_cke(b_cke), .sdram_cmds(b_cmds),
    .sdram_ba(b_ba), .sdram_addrs(b_addrs), .sdram_init_done(b_done)
  );

  sdram_init_seq #(
    .CLK_FREQ_MHZ(1), .POWERUP_US(5), .CAS_LATENCY(2), .BURST_LEN(0), .BURST_TYPE(1),
    .WRITE_BURST(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .init_req(no_req), .sdram_cke(c_cke), .sdram_cmds(c_cmds),
    .sdram_ba(c_ba), .sdram_addrs(c_addrs), .sdram_init_done(c_done)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = -1;
  int   base_a = 0;
  int   pu_a = 10000;
  logic prev_done_a = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected bus at r cycles after the sequence start, from the command-offset rules.
  function automatic exp_t model(input int r, input int pu, input int trp, input int trfc,
                                 input int tmrd, input int rn, input logic [12:0] mode);
    exp_t e;
    int   mrs_at;
    e.cmd  = NOP;
    e.addr = 13'h1FFF;
    e.done = 1'b0;
    mrs_at = pu + trp + rn * trfc;
    if (r == pu) e.cmd = PRE;
    for (int k = 0; k < rn; k++) if (r == pu + trp + k * trfc) e.cmd = REF;
    if (r == mrs_at) begin
      e.cmd  = MRS;
      e.addr = mode;
    end
    if (r >= mrs_at + tmrd) e.done = 1'b1;
    return e;
  endfunction

  task automatic chk_dut(input string tag, input exp_t e, input logic cke, input logic [3:0] cmds,
                         input logic [1:0] ba, input logic [12:0] addrs, input logic done);
    chk({tag, "_cke"}, 32'(cke), 32'd1);
    chk({tag, "_cmd"}, 32'(cmds), 32'(e.cmd));
    chk({tag, "_ba"}, 32'(ba), 32'd0);
    chk({tag, "_addr"}, 32'(addrs), 32'(e.addr));
    chk({tag, "_done"}, 32'(done), 32'(e.done));
  endtask

  task automatic chk_reset(input string tag, input logic cke, input logic [3:0] cmds,
                           input logic [1:0] ba, input logic [12:0] addrs, input logic done);
    chk({tag, "_rst_cke"}, 32'(cke), 32'd0);
    chk({tag, "_rst_cmd"}, 32'(cmds), 32'(NOP));
    chk({tag, "_rst_ba"}, 32'(ba), 32'd0);
    chk({tag, "_rst_addr"}, 32'(addrs), 32'h1FFF);
    chk({tag, "_rst_done"}, 32'(done), 32'd0);
  endtask

  // One clock edge, then compare all instances against the model #1 later.
  task automatic step();
    logic req;
    exp_t ea, eb, ec;
    req = init_req;
    @(posedge clk);
    cyc++;
    if (req && prev_done_a) begin
      base_a = cyc;
      pu_a   = 0;
    end
    #1;
    ea = model(cyc - base_a, pu_a, 3, 7, 2, 2, 13'h0032);
    eb = model(cyc, 10, 1, 1, 1, 8, 13'h0032);
    ec = model(cyc, 5, 3, 7, 2, 2, 13'h022F);
    chk_dut("a", ea, a_cke, a_cmds, a_ba, a_addrs, a_done);
    chk_dut("b", eb, b_cke, b_cmds, b_ba, b_addrs, b_done);
    chk_dut("c", ec, c_cke, c_cmds, c_ba, c_addrs, c_done);
    prev_done_a = ea.done;
  endtask

  task automatic pulse_req();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
  endtask

  // Assert reset away from a clock edge, check outputs clear at once, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset("a", a_cke, a_cmds, a_ba, a_addrs, a_done);
    chk_reset("b", b_cke, b_cmds, b_ba, b_addrs, b_done);
    chk_reset("c", c_cke, c_cmds, c_ba, c_addrs, c_done);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    cyc         = -1;
    base_a      = 0;
    pu_a        = 10000;
    prev_done_a = 1'b0;
  endtask

  vec_t tbl[$];
  int   rnd1, rnd2, gap, mid;

  initial begin
    tbl.push_back('{0,     NOP, 13'h1FFF, 1'b0});
    tbl.push_back('{9999,  NOP, 13'h1FFF, 1'b0});
    tbl.push_back('{10000, PRE, 13'h1FFF, 1'b0});
    tbl.push_back('{10001, NOP, 13'h1FFF, 1'b0});
    tbl.push_back('{10003, REF, 13'h1FFF, 1'b0});
    tbl.push_back('{10010, REF, 13'h1FFF, 1'b0});
    tbl.push_back('{10017, MRS, 13'h0032, 1'b0});
    tbl.push_back('{10018, NOP, 13'h1FFF, 1'b0});
    tbl.push_back('{10019, NOP, 13'h1FFF, 1'b1});
    rnd1 = int'($urandom_range(200, 9990));
    rnd2 = int'($urandom_range(1, 9990));

    #2;
    do_reset();

    // Full default sequence with ignored requests in WAIT_PU, TRFC and at random points.
    while (cyc < 10023) begin
      step();
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].cycle == cyc) begin
          chk("tbl_cmd", 32'(a_cmds), 32'(tbl[i].cmd));
          chk("tbl_addr", 32'(a_addrs), 32'(tbl[i].addr));
          chk("tbl_done", 32'(a_done), 32'(tbl[i].done));
        end
      end
      if (cyc == 19) chk("b_mrs_cmd", 32'(b_cmds), 32'(MRS));
      if (cyc == 20) chk("b_done_rise", 32'(b_done), 32'd1);
      if (cyc == 22) chk("c_mode_word", 32'(c_addrs), 32'h022F);
      if (cyc == 100 || cyc == 10005 || cyc == rnd1 || cyc == rnd2) pulse_req();
    end

    // Re-init five cycles after done: PRE immediately, no power-up wait.
    pulse_req();
    chk("reinit_pre", 32'(a_cmds), 32'(PRE));
    chk("reinit_done_fall", 32'(a_done), 32'd0);
    while (cyc < 10050) begin
      step();
      if (cyc == 10027 || cyc == 10034) chk("reinit_ref", 32'(a_cmds), 32'(REF));
      if (cyc == 10041) chk("reinit_mrs", 32'(a_addrs), 32'h0032);
      if (cyc == 10042) chk("reinit_done_early", 32'(a_done), 32'd0);
      if (cyc == 10043) chk("reinit_done", 32'(a_done), 32'd1);
    end

    // Random re-inits, each with an ignored request during the replay.
    for (int n = 0; n < 3; n++) begin
      gap = int'($urandom_range(1, 20));
      mid = int'($urandom_range(1, 15));
      repeat (gap) step();
      pulse_req();
      repeat (mid) step();
      pulse_req();
      repeat (25) step();
    end

    // Reset two cycles after the first REF of a fresh sequence, then a full rerun.
    do_reset();
    while (cyc < 10005) step();
    do_reset();
    while (cyc < 10020) begin
      step();
      if (cyc == 10000) chk("rerun_pre", 32'(a_cmds), 32'(PRE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
